// File: rtl/video_address_gen.sv
// video_address_gen
//   Generates byte fetch addresses for a raster display. Each falling edge of
//   the timing generator's DA0 strobe requests one byte. Rows are repeated a
//   mode-dependent number of scan lines by rewinding to the row start on HSn.
//   A falling edge of FSn reloads the frame base.
//
//   All state changes on the falling edge of i_clk. i_rst is an asynchronous,
//   active-high reset.
//
//   Build option: define VIDEO_ADDR_SYNC_EN to pass HSn/FSn/DA0 through
//   two-flop synchronisers. This adds one cycle of latency. When the macro is
//   undefined, the inputs get a single register stage.
//
// Ports
//   i_clk          system clock (falling-edge active)
//   i_rst          async reset, active high
//   i_hsn          horizontal sync, active low
//   i_fsn          field sync, active low
//   i_da0          pixel-data address strobe (falling edge = one byte)
//   i_vmode[2:0]   display mode: bytes/row and lines/row
//   i_base[6:0]    display base page, 512-byte granularity
//   o_fetch_addr   byte address to fetch, valid with o_fetch_stb
//   o_fetch_stb    one-cycle fetch request
//   o_frame_start  one-cycle pulse after a detected FSn falling edge
module video_address_gen (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsn,
  input  logic        i_fsn,
  input  logic        i_da0,
  input  logic [2:0]  i_vmode,
  input  logic [6:0]  i_base,
  output logic [15:0] o_fetch_addr,
  output logic        o_fetch_stb,
  output logic        o_frame_start
);

  // Bit order of the input vectors: {hsn, fsn, da0}.
  logic [2:0] r_in;       // registered inputs (edge detector "current")
  logic [2:0] r_in_prev;  // previous value (edge detector "previous")

`ifdef VIDEO_ADDR_SYNC_EN
  logic [2:0] r_sync1;
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 3'b111;
      r_in      <= 3'b111;
      r_in_prev <= 3'b111;
    end else begin
      r_sync1   <= {i_hsn, i_fsn, i_da0};
      r_in      <= r_sync1;
      r_in_prev <= r_in;
    end
  end
`else
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in      <= 3'b111;
      r_in_prev <= 3'b111;
    end else begin
      r_in      <= {i_hsn, i_fsn, i_da0};
      r_in_prev <= r_in;
    end
  end
`endif

  logic w_hs_fall, w_fs_fall, w_da_fall, w_fsn_q;
  assign w_hs_fall = r_in_prev[2] & ~r_in[2];
  assign w_fs_fall = r_in_prev[1] & ~r_in[1];
  assign w_da_fall = r_in_prev[0] & ~r_in[0];
  assign w_fsn_q   = r_in[1];

  // Mode table
  logic [5:0] w_bpr;
  logic [3:0] w_lpr;
  always_comb begin
    w_bpr = 6'd32;
    w_lpr = 4'd1;
    case (i_vmode)
      3'd0:    begin w_bpr = 6'd32; w_lpr = 4'd12; end
      3'd1:    begin w_bpr = 6'd16; w_lpr = 4'd3;  end
      3'd2:    begin w_bpr = 6'd32; w_lpr = 4'd3;  end
      3'd3:    begin w_bpr = 6'd16; w_lpr = 4'd2;  end
      3'd4:    begin w_bpr = 6'd32; w_lpr = 4'd2;  end
      3'd5:    begin w_bpr = 6'd16; w_lpr = 4'd1;  end
      default: begin w_bpr = 6'd32; w_lpr = 4'd1;  end
    endcase
  end

  logic [15:0] r_ptr, r_row, r_fetch_addr;
  logic [5:0]  r_bc;
  logic [3:0]  r_rep;
  logic        r_lf, r_armed, r_fetch_stb, r_frame_start;

  logic [15:0] w_ptr_n, w_row_n, w_addr_n;
  logic [5:0]  w_bc_n;
  logic [3:0]  w_rep_n;
  logic        w_lf_n, w_armed_n, w_stb_n, w_fs_n;

  always_comb begin
    w_ptr_n   = r_ptr;
    w_row_n   = r_row;
    w_bc_n    = r_bc;
    w_rep_n   = r_rep;
    w_lf_n    = r_lf;
    w_armed_n = r_armed;
    w_addr_n  = r_fetch_addr;
    w_stb_n   = 1'b0;
    w_fs_n    = 1'b0;
    if (w_fs_fall) begin
      // Frame start wins over any same-cycle HSn/DA0 edge.
      w_ptr_n   = {i_base, 9'b0};
      w_row_n   = {i_base, 9'b0};
      w_bc_n    = '0;
      w_rep_n   = '0;
      w_lf_n    = 1'b0;
      w_armed_n = 1'b1;
      w_fs_n    = 1'b1;
    end else if (r_armed && w_fsn_q) begin
      // Fetching stays disabled after reset until the first frame start.
      if (w_da_fall && (r_bc < w_bpr)) begin
        w_stb_n  = 1'b1;
        w_addr_n = r_ptr;
        w_ptr_n  = r_ptr + 16'd1;
        w_bc_n   = r_bc + 6'd1;
        w_lf_n   = 1'b1;
      end
      // A same-cycle DA0 fetch is applied first. The HSn rule then sees the
      // incremented pointer.
      if (w_hs_fall && w_lf_n) begin
        w_bc_n = '0;
        w_lf_n = 1'b0;
        // Use >= so that a mode switch to fewer lines/row still closes the row.
        if (r_rep >= (w_lpr - 4'd1)) begin
          w_rep_n = '0;
          w_row_n = w_ptr_n;
        end else begin
          w_rep_n = r_rep + 4'd1;
          w_ptr_n = r_row;
        end
      end
    end
  end

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr         <= '0;
      r_row         <= '0;
      r_bc          <= '0;
      r_rep         <= '0;
      r_lf          <= 1'b0;
      r_armed       <= 1'b0;
      r_fetch_addr  <= '0;
      r_fetch_stb   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_ptr         <= w_ptr_n;
      r_row         <= w_row_n;
      r_bc          <= w_bc_n;
      r_rep         <= w_rep_n;
      r_lf          <= w_lf_n;
      r_armed       <= w_armed_n;
      r_fetch_addr  <= w_addr_n;
      r_fetch_stb   <= w_stb_n;
      r_frame_start <= w_fs_n;
    end
  end

  assign o_fetch_addr  = r_fetch_addr;
  assign o_fetch_stb   = r_fetch_stb;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_video_address_gen.sv
module tb_video_address_gen;

`ifdef VIDEO_ADDR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst, hsn, fsn, da0;
  logic [2:0] vmode;
  logic [6:0] base;
  logic [15:0] fetch_addr;
  logic fetch_stb, frame_start;

  always #5 clk = ~clk;

  video_address_gen dut (
    .i_clk(clk), .i_rst(rst), .i_hsn(hsn), .i_fsn(fsn), .i_da0(da0),
    .i_vmode(vmode), .i_base(base),
    .o_fetch_addr(fetch_addr), .o_fetch_stb(fetch_stb), .o_frame_start(frame_start)
  );

  int vecs = 0, errs = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int fs_cnt = 0;

  // Outputs change on the falling edge, so they are sampled on the rising edge.
  always @(posedge clk) begin
    if (fetch_stb) got_q.push_back(fetch_addr);
    if (frame_start) fs_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: works on the sequence of input events, not on cycles.
  int bpr_t[8] = '{32, 16, 32, 16, 32, 16, 32, 32};
  int lpr_t[8] = '{12, 3, 3, 2, 2, 1, 1, 1};
  logic [15:0] m_ptr, m_row;
  int m_bc, m_rc;
  bit m_lf, m_armed;

  task automatic mdl_frame();
    m_ptr = {base, 9'b0}; m_row = m_ptr; m_bc = 0; m_rc = 0; m_lf = 0; m_armed = 1;
  endtask
  task automatic mdl_da0();
    if (m_armed && m_bc < bpr_t[vmode]) begin
      exp_q.push_back(m_ptr); m_ptr = m_ptr + 16'd1; m_bc++; m_lf = 1;
    end
  endtask
  task automatic mdl_hsn();
    if (m_armed && m_lf) begin
      m_bc = 0; m_lf = 0;
      if (m_rc >= lpr_t[vmode] - 1) begin m_rc = 0; m_row = m_ptr; end
      else begin m_rc++; m_ptr = m_row; end
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic da0_pulse();
    da0 = 0; cyc(); da0 = 1; cyc(); mdl_da0();
  endtask
  task automatic hsn_pulse();
    hsn = 0; cyc(2); hsn = 1; cyc(); mdl_hsn();
  endtask
  task automatic fsn_pulse();
    fsn = 0; cyc(2); fsn = 1; cyc(); mdl_frame();
  endtask
  task automatic hs_da_pulse();
    hsn = 0; da0 = 0; cyc(); da0 = 1; cyc(); hsn = 1; cyc(); mdl_da0(); mdl_hsn();
  endtask

  task automatic check_q(input string name);
    int n;
    cyc(LAT + 3);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_addr"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1; cyc(2);
    chk("rst_addr", fetch_addr, 16'h0000);
    chk("rst_stb", fetch_stb, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    rst = 0; cyc(2);
    m_armed = 0; m_lf = 0; m_bc = 0; m_rc = 0; m_ptr = 0; m_row = 0;
    got_q.delete(); exp_q.delete();
  endtask

  typedef struct {
    logic [2:0] vm; logic [6:0] bs; int lines; int da0s;
    logic [15:0] exp_last_first; int exp_cnt;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fs0, idx, nl, nd;
    logic [15:0] last_first;
    tbl[0] = '{3'd1, 7'h02, 4, 16, 16'h0410, 64};
    tbl[1] = '{3'd5, 7'h02, 2, 20, 16'h0410, 32};
    tbl[2] = '{3'd0, 7'h10, 13, 32, 16'h2020, 416};
    tbl[3] = '{3'd3, 7'h01, 3, 10, 16'h020A, 30};
    tbl[4] = '{3'd6, 7'h7F, 17, 32, 16'h0000, 544};
    tbl[5] = '{3'd7, 7'h00, 2, 40, 16'h0020, 64};
    tbl[6] = '{3'd2, 7'h03, 4, 32, 16'h0620, 128};
    tbl[7] = '{3'd4, 7'h40, 3, 5, 16'h8005, 15};

    rst = 1; hsn = 1; fsn = 1; da0 = 1; vmode = 0; base = 0;
    do_reset();

    // Frame start pulse width and latency (Base=0x02 -> first fetch 0x0400)
    base = 7'h02; vmode = 3'd1;
    fsn = 0;
    for (int k = 0; k <= LAT; k++) begin cyc(); chk("fs_lat", frame_start, (k == LAT)); end
    cyc(); chk("fs_single", frame_start, 1'b0);
    fsn = 1; cyc(2); mdl_frame();
    // DA0 -> FetchStb latency
    da0 = 0;
    for (int k = 0; k <= LAT; k++) begin cyc(); chk("da_lat", fetch_stb, (k == LAT)); end
    chk("first_addr", fetch_addr, 16'h0400);
    da0 = 1; cyc(); chk("stb_single", fetch_stb, 1'b0);
    mdl_da0();
    check_q("first");

    // Table-driven frames
    for (int t = 0; t < 8; t++) begin
      vmode = tbl[t].vm; base = tbl[t].bs; fs0 = fs_cnt;
      fsn_pulse();
      idx = 0;
      for (int l = 0; l < tbl[t].lines; l++) begin
        if (l == tbl[t].lines - 1) begin cyc(LAT + 2); idx = got_q.size(); end
        for (int d = 0; d < tbl[t].da0s; d++) da0_pulse();
        hsn_pulse();
      end
      cyc(LAT + 3);
      chk("tbl_fs", fs_cnt - fs0, 1);
      chk("tbl_cnt", got_q.size(), tbl[t].exp_cnt);
      last_first = (idx < got_q.size()) ? got_q[idx] : 16'hDEAD;
      chk("tbl_lastline", last_first, tbl[t].exp_last_first);
      check_q("tbl");
    end

    // Blanking lines do not advance the repeat count
    vmode = 3'd1; base = 7'h02; fsn_pulse();
    repeat (3) hsn_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int d = 0; d < 16; d++) da0_pulse();
      hsn_pulse();
    end
    check_q("blank");

    // FSn low: DA0/HSn ignored
    fsn = 0; cyc(3);
    repeat (3) begin da0 = 0; cyc(); da0 = 1; cyc(); end
    hsn = 0; cyc(2); hsn = 1; cyc();
    fsn = 1; cyc(3); mdl_frame();
    check_q("fsn_low");

    // Simultaneous HSn + DA0 (last byte of line)
    vmode = 3'd5; base = 7'h05; fsn_pulse();
    for (int d = 0; d < 15; d++) da0_pulse();
    hs_da_pulse();
    for (int d = 0; d < 4; d++) da0_pulse();
    check_q("hs_da");

    // Simultaneous FSn + HSn mid-line: frame restart only
    vmode = 3'd6; base = 7'h11;
    for (int d = 0; d < 7; d++) da0_pulse();
    fs0 = fs_cnt;
    fsn = 0; hsn = 0; cyc(2); fsn = 1; hsn = 1; cyc(); mdl_frame();
    for (int d = 0; d < 3; d++) da0_pulse();
    check_q("fs_hs");
    chk("fs_hs_fs", fs_cnt - fs0, 1);

    // Reset mid-line: pending fetch dropped, none until next FSn
    da0 = 0; cyc(); rst = 1; cyc();
    chk("rst_stop_stb", fetch_stb, 1'b0);
    chk("rst_mid_addr", fetch_addr, 16'h0000);
    rst = 0; da0 = 1; cyc(2);
    m_armed = 0;
    for (int d = 0; d < 4; d++) da0_pulse();
    hsn_pulse();
    check_q("post_rst");
    fsn_pulse();
    for (int d = 0; d < 4; d++) da0_pulse();
    check_q("rearm");

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      vmode = 3'($urandom_range(0, 7)); base = 7'($urandom);
      fsn_pulse();
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) begin
        if ($urandom_range(0, 5) == 0) hsn_pulse();
        nd = $urandom_range(0, 36);
        for (int d = 0; d < nd; d++) begin
          if (d == nd / 2 && $urandom_range(0, 4) == 0) begin
            cyc(LAT + 2); vmode = 3'($urandom_range(0, 7));
          end
          da0_pulse();
        end
        if ($urandom_range(0, 4) == 0) hs_da_pulse();
        else hsn_pulse();
      end
      check_q("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
